va_034_icu: RTL
===============

Name: va_034_icu

Overview:
- Clocked, parametrised successor to the VP1-034 address-compare/interrupt-vector function.
- Sits on the inverted Q-bus (nAD) beside peripheral logic. Decodes a base address window into nSB.
- Collects NCH peripheral requests with per-channel enable and fixed priority, raises nVIRQ, and answers interrupt-acknowledge cycles with a per-channel vector.
- Passes IAK down the daisy chain when it has nothing pending.

Parameters:
NCH, 4, number of interrupt channels (2..16); CW = clog2(NCH) is derived.
VW, 4, width of the vector base field PIN_V; constraint 2+VW+CW <= 16.
AW, 10, width of the address compare field.
ALSB, 3, lowest nAD bit compared; constraint ALSB+AW <= 16.

Ports:
PIN_CLK  in  1  system clock; all state changes on its rising edge.
PIN_RST  in  1  reset, asynchronous, active-high.
PIN_nAD  inout  16  inverted Q-bus address/data.
PIN_A  in  AW  address compare value, same polarity as the bus.
PIN_V  in  VW  vector base, true polarity.
PIN_IE  in  NCH  per-channel interrupt enable, active-high.
PIN_nIRQ  in  NCH  peripheral requests, active-low.
PIN_nBS  in  1  bank-select, active-low.
PIN_nSYNC  in  1  bus sync, active-low.
PIN_nDIN  in  1  data-in strobe, active-low.
PIN_nIAKI  in  1  IAK daisy-chain input, active-low.
PIN_nIAKO  out  1  IAK daisy-chain output, active-low.
PIN_nVIRQ  out  1  interrupt request to the processor, active-low.
PIN_nRPLY  out  1  reply, open-drain: 0 or Z.
PIN_nSB  out  1  address-window select, active-low.
PIN_nACK  out  NCH  per-channel acknowledge pulse, active-low.

Behaviour:
- Input timing: all bus inputs are synchronous to PIN_CLK. Each input has a registered copy (prev) for edge detection.
- Reset (async, any state): match=0, pend=0, FSM=IDLE.
  - Outputs: nSB=1, nVIRQ=1, nIAKO=1, nACK=all 1, nRPLY=Z, nAD=all Z.
  - Applies equally mid-cycle; the bus is released in the same cycle reset rises.
- Address match:
  - On an nSYNC falling edge (prev 1, now 0): match <= ~nBS & (nAD[ALSB+AW-1:ALSB] == PIN_A).
  - match clears on the first clock with nSYNC=1.
  - nSB = ~match, registered, so nSB is valid 1 clock after the nSYNC fall.
- Request capture:
  - pend[i] sets on an nIRQ[i] falling edge while IE[i]=1.
  - pend[i] clears when IE[i]=0, or on service of channel i.
  - If set and service-clear coincide, set wins.
  - nVIRQ = ~|pend, registered (1-clock latency).
- IAK FSM:
  - IDLE: when nIAKI=0 & nDIN=0 are sampled:
    - if |pend: latch ch = lowest pending index → GRANT.
    - else → PASS.
  - GRANT:
    - nRPLY=0, nIAKO=1.
    - nAD[2+VW+CW-1:2] = ~{PIN_V, ch}; all other nAD bits Z.
    - ch stays frozen even if higher-priority requests arrive.
    - On nDIN=1: release nAD and nRPLY the same clock, clear pend[ch], nACK[ch]=0 for exactly 1 clock → WAIT.
  - PASS: nIAKO=0 while nIAKI=0; on nIAKI=1 → IDLE with nIAKO=1.
  - WAIT: on nIAKI=1 → IDLE.
  - An IAK arriving with nDIN already low is treated the same as above.
  - If nIAKI rises in GRANT before nDIN rises: still complete on nDIN=1.
- Outside GRANT: nAD is never driven.
- Vector value on the bus: true vector = {V, ch, 2'b00}.

Test Plan:
- Reset: assert PIN_RST during GRANT → same cycle nRPLY=Z, nAD=Z, nIAKO=1, nVIRQ=1; pend=0 after release.
- Address match: A=10'o0770, nAD[12:3]=10'o0770, nBS=0, nSYNC falls → nSB=0 one clock later; nBS=1 → nSB stays 1; nSYNC rises → nSB=1.
- Vector (NCH=4, VW=4, V=4'b1100):
  - nIRQ[2] falls, IE=4'hF → nVIRQ=0 next clock.
  - IAKI+DIN low → nRPLY=0, nAD[7:2]=6'b001101 (vector 0o310), nIAKO=1.
  - DIN high → nACK[2] low 1 clock, nVIRQ=1.
- Priority: pend on ch1 and ch3 → first IAK serves ch1 (nAD[7:2]=~6'b110001); second IAK serves ch3. ch0 raised during GRANT of ch1 does not change the vector.
- Pass-through: no pend, IAKI+DIN low → nIAKO=0, nRPLY=Z; IAKI high → nIAKO=1.
- Mask/collision: IE[1]=0 with a pending ch1 → pend cleared, nVIRQ=1. nIRQ[3] re-falls on the clear clock → pend[3] remains 1.

Source files
------------

// File: rtl/va_034_icu_if.sv
// Purpose: Q-bus control and interrupt handshake bundle between bus-side logic and va_034_icu.
// Latency: wires only; the shared tri-state nets (nAD, nRPLY) stay as plain ports on the ICU.
// Backpressure: none; the bus strobes nSYNC/nDIN/nIAKI pace every transfer.
interface va_034_icu_if #(
  parameter int NCH = 4,
  parameter int VW  = 4,
  parameter int AW  = 10
) ();
  logic [AW-1:0]  PIN_A;
  logic [VW-1:0]  PIN_V;
  logic [NCH-1:0] PIN_IE;
  logic [NCH-1:0] PIN_nIRQ;
  logic           PIN_nBS;
  logic           PIN_nSYNC;
  logic           PIN_nDIN;
  logic           PIN_nIAKI;
  logic           PIN_nIAKO;
  logic           PIN_nVIRQ;
  logic           PIN_nSB;
  logic [NCH-1:0] PIN_nACK;

  // ICU side
  modport slave (
    input  PIN_A, PIN_V, PIN_IE, PIN_nIRQ, PIN_nBS, PIN_nSYNC, PIN_nDIN, PIN_nIAKI,
    output PIN_nIAKO, PIN_nVIRQ, PIN_nSB, PIN_nACK
  );

  // Bus / peripheral side
  modport master (
    output PIN_A, PIN_V, PIN_IE, PIN_nIRQ, PIN_nBS, PIN_nSYNC, PIN_nDIN, PIN_nIAKI,
    input  PIN_nIAKO, PIN_nVIRQ, PIN_nSB, PIN_nACK
  );
endinterface

// File: rtl/va_034_icu.sv
// Purpose: Q-bus address-window decode plus NCH-channel fixed-priority interrupt controller with vector reply.
// Latency: nSB/nVIRQ/nIAKO/nACK/nRPLY/nAD all change on the clock edge that samples their cause.
// Backpressure: none; nRPLY is held low until the processor raises nDIN, IAK passes down the chain when idle.
module va_034_icu #(
  parameter int NCH  = 4,
  parameter int VW   = 4,
  parameter int AW   = 10,
  parameter int ALSB = 3
) (
  input  logic        PIN_CLK,
  input  logic        PIN_RST,
  inout  wire  [15:0] PIN_nAD,
  output wire         PIN_nRPLY,
  va_034_icu_if.slave bus
);

  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int VLSB = 2;
  localparam int VMSB = 2 + VW + CW - 1;

  typedef enum logic [1:0] {IDLE, GRANT, PASS, WAIT} state_t;

  state_t         state_q;
  logic [CW-1:0]  ch_q;
  logic           drv_q;
  logic           niako_q;
  logic [NCH-1:0] nack_q;

  logic [NCH-1:0] pend_q, pend_d;
  logic           match_q, match_d;
  logic           nsb_q, nvirq_q;
  logic           nsync_prev_q;
  logic [NCH-1:0] nirq_prev_q;

  logic [CW-1:0]  low_idx;
  logic           svc;
  logic [NCH-1:0] svc_mask;
  logic [NCH-1:0] set_mask;
  logic [VW+CW-1:0] vec_n;

  // Only the compare field of nAD is read; fold the whole bus so no bit dangles.
  wire unused_nad = ^PIN_nAD;

  // Lowest-numbered pending channel has priority.
  always_comb begin
    low_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = CW'(i);
    end
  end

  // Service of the granted channel completes on the clock that sees nDIN high.
  always_comb begin
    svc      = (state_q == GRANT) && bus.PIN_nDIN;
    svc_mask = '0;
    if (svc) svc_mask[ch_q] = 1'b1;
  end

  // Request capture: new falling edge on an enabled line wins over any clear.
  always_comb begin
    set_mask = nirq_prev_q & ~bus.PIN_nIRQ & bus.PIN_IE;
    pend_d   = set_mask | (pend_q & bus.PIN_IE & ~svc_mask);
  end

  // Address window: latched on nSYNC falling edge, dropped while nSYNC is high.
  always_comb begin
    match_d = match_q;
    if (bus.PIN_nSYNC) begin
      match_d = 1'b0;
    end else if (nsync_prev_q) begin
      match_d = ~bus.PIN_nBS & (PIN_nAD[ALSB+AW-1:ALSB] == bus.PIN_A);
    end
  end

  // Edge-detect history, pending set, address match and their registered outputs.
  always_ff @(posedge PIN_CLK or posedge PIN_RST) begin
    if (PIN_RST) begin
      match_q      <= 1'b0;
      nsb_q        <= 1'b1;
      pend_q       <= '0;
      nvirq_q      <= 1'b1;
      nsync_prev_q <= 1'b1;
      nirq_prev_q  <= '1;
    end else begin
      match_q      <= match_d;
      nsb_q        <= ~match_d;
      pend_q       <= pend_d;
      nvirq_q      <= ~|pend_d;
      nsync_prev_q <= bus.PIN_nSYNC;
      nirq_prev_q  <= bus.PIN_nIRQ;
    end
  end

  // IAK sequencer: grant the lowest pending channel or pass IAK down the chain.
  always_ff @(posedge PIN_CLK or posedge PIN_RST) begin
    if (PIN_RST) begin
      state_q <= IDLE;
      ch_q    <= '0;
      drv_q   <= 1'b0;
      niako_q <= 1'b1;
      nack_q  <= '1;
    end else begin
      nack_q <= '1;
      case (state_q)
        IDLE: begin
          if (!bus.PIN_nIAKI && !bus.PIN_nDIN) begin
            if (|pend_q) begin
              ch_q    <= low_idx;
              drv_q   <= 1'b1;
              state_q <= GRANT;
            end else begin
              niako_q <= 1'b0;
              state_q <= PASS;
            end
          end
        end
        GRANT: begin
          // ch_q stays frozen here; late higher-priority requests wait for the next IAK.
          if (bus.PIN_nDIN) begin
            drv_q        <= 1'b0;
            nack_q[ch_q] <= 1'b0;
            state_q      <= WAIT;
          end
        end
        PASS: begin
          if (bus.PIN_nIAKI) begin
            niako_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (bus.PIN_nIAKI) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Inverted vector field {V, ch}; the two low address bits read as 1 (true 0) via the bus pull-ups.
  assign vec_n = ~{bus.PIN_V, ch_q};

  for (genvar b = 0; b < 16; b++) begin : g_nad
    if (b >= VLSB && b <= VMSB) begin : g_vec
      assign PIN_nAD[b] = drv_q ? vec_n[b-VLSB] : 1'bz;
    end else begin : g_hiz
      assign PIN_nAD[b] = 1'bz;
    end
  end

  assign PIN_nRPLY     = drv_q ? 1'b0 : 1'bz;
  assign bus.PIN_nSB   = nsb_q;
  assign bus.PIN_nVIRQ = nvirq_q;
  assign bus.PIN_nIAKO = niako_q;
  assign bus.PIN_nACK  = nack_q;

endmodule
